ula_mc: RTL and testbench

ULA_MC -- requirements
Module: ula_mc

---
 rtl/ula_mc_pkg.sv | 25 ++
 rtl/ula_mc_iter.sv | 86 ++++++++
 rtl/ula_mc.sv | 186 ++++++++++++++++++
 tb/tb_ula_mc.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_mc_pkg.sv
// Shared opcode constants and FSM state type for the ula_mc ALU.
package ula_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    localparam int unsigned LUI_IMM_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/ula_mc_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and restoring divide.
// Divide mode exists only when ULA_MC_DIV_EN is defined.
module ula_mc_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_lo_c,
    output logic [WIDTH-1:0] o_hi_c
);
    import ula_mc_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             w_div;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic [WIDTH+1:0] w_sum;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

`ifdef ULA_MC_DIV_EN
    logic r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_div <= 1'b0;
        else if (i_start) r_div <= i_div;
    end
    assign w_div = r_div;
`else
    assign w_div = 1'b0;
`endif

    // One adder serves both modes: hi+multiplicand, or trial remainder minus divisor.
    always_comb begin
        w_trial  = {r_hi, r_lo[WIDTH-1]};
        w_add_a  = w_div ? w_trial : {1'b0, r_hi};
        w_add_b  = w_div ? ~{1'b0, r_opnd} : (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_sum    = (WIDTH+2)'(w_add_a) + (WIDTH+2)'(w_add_b) + (WIDTH+2)'(w_div);
        w_ge     = w_sum[WIDTH+1];
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        if (w_div) begin
            w_hi_nxt = w_ge ? w_sum[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    assign o_done_c = r_busy && (r_cnt == CW'(WIDTH-1));
    assign o_lo_c   = w_lo_nxt;
    assign o_hi_c   = w_hi_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= i_div ? i_a : i_b;
            r_opnd <= i_div ? i_b : i_a;
        end else if (r_busy) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (o_done_c) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MULU and optional DIVU.
// Define ULA_MC_DIV_EN to build the divider; otherwise opcode 1001 acts as ADD.
module ula_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             dz_flag
);
    import ula_mc_pkg::*;

    state_e           r_state, w_state_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [WIDTH-1:0] r_result_hi, w_result_hi_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_dz, w_dz_nxt;
    logic             w_iter_start, w_iter_div, w_iter_done;
    logic [WIDTH-1:0] w_iter_lo, w_iter_hi;
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry, w_alu_ovf;

    ula_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iter_start),
        .i_div    (w_iter_div),
        .i_a      (in1),
        .i_b      (in2),
        .o_done_c (w_iter_done),
        .o_lo_c   (w_iter_lo),
        .o_hi_c   (w_iter_hi)
    );

    // Single-cycle ALU; any unlisted opcode falls through to ADD.
    always_comb begin
        w_add       = {1'b0, in1} + {1'b0, in2};
        w_sub       = {1'b0, in1} - {1'b0, in2};
        w_alu_res   = w_add[WIDTH-1:0];
        w_alu_carry = w_add[WIDTH];
        w_alu_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_add[WIDTH-1] != in1[WIDTH-1]);
        if (op != OP_ADD && op != OP_MULU && op != OP_DIVU) begin
            w_alu_carry = 1'b0;
            w_alu_ovf   = 1'b0;
        end
        case (op)
            OP_AND: w_alu_res = in1 & in2;
            OP_OR:  w_alu_res = in1 | in2;
            OP_SUB: begin
                w_alu_res   = w_sub[WIDTH-1:0];
                w_alu_carry = w_sub[WIDTH];
                w_alu_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_sub[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLT: w_alu_res = (in1 < in2) ? WIDTH'(1) : '0;
            OP_LUI: w_alu_res = WIDTH'({LUI_IMM_W'(in2), LUI_IMM_W'(0)});
            OP_NOR: w_alu_res = ~(in1 | in2);
            OP_XOR: w_alu_res = in1 ^ in2;
            OP_SLL: w_alu_res = in2 << shamt;
            OP_SRL: w_alu_res = in2 >> shamt;
            default: begin
                w_alu_carry = w_add[WIDTH];
                w_alu_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_add[WIDTH-1] != in1[WIDTH-1]);
            end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = 1'b0;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_carry_nxt     = r_carry;
        w_ovf_nxt       = r_ovf;
        w_dz_nxt        = r_dz;
        w_iter_start    = 1'b0;
        w_iter_div      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_MULU) begin
                        w_iter_start = 1'b1;
                        w_state_nxt  = MUL;
                    end
`ifdef ULA_MC_DIV_EN
                    else if (op == OP_DIVU) begin
                        if (in2 == '0) begin
                            w_out_valid_nxt = 1'b1;
                            w_result_nxt    = '1;
                            w_result_hi_nxt = in1;
                            w_carry_nxt     = 1'b0;
                            w_ovf_nxt       = 1'b0;
                            w_dz_nxt        = 1'b1;
                        end else begin
                            w_iter_start = 1'b1;
                            w_iter_div   = 1'b1;
                            w_state_nxt  = DIV;
                        end
                    end
`endif
                    else begin
                        w_out_valid_nxt = 1'b1;
                        w_result_nxt    = w_alu_res;
                        w_result_hi_nxt = '0;
                        w_carry_nxt     = w_alu_carry;
                        w_ovf_nxt       = w_alu_ovf;
                        w_dz_nxt        = 1'b0;
                    end
                end
            end
            MUL: begin
                if (w_iter_done) begin
                    w_out_valid_nxt = 1'b1;
                    w_result_nxt    = w_iter_lo;
                    w_result_hi_nxt = w_iter_hi;
                    w_carry_nxt     = 1'b0;
                    w_ovf_nxt       = (w_iter_hi != '0);
                    w_dz_nxt        = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
`ifdef ULA_MC_DIV_EN
            DIV: begin
                if (w_iter_done) begin
                    w_out_valid_nxt = 1'b1;
                    w_result_nxt    = w_iter_lo;
                    w_result_hi_nxt = w_iter_hi;
                    w_carry_nxt     = 1'b0;
                    w_ovf_nxt       = 1'b0;
                    w_dz_nxt        = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
        w_zero_nxt = w_out_valid_nxt ? (w_result_nxt == '0) : r_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_zero      <= w_zero_nxt;
            r_carry     <= w_carry_nxt;
            r_ovf       <= w_ovf_nxt;
            r_dz        <= w_dz_nxt;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign result_hi  = r_result_hi;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign ovf_flag   = r_ovf;
    assign dz_flag    = r_dz;

endmodule

// File: tb/tb_ula_mc.sv
// Scoreboard bench for ula_mc: 32-bit instance for most scenarios, 16-bit instance for width checks.
module tb_ula_mc;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110,
                           C_SLT = 4'b0111, C_MUL = 4'b1000, C_DIV = 4'b1001, C_LUI = 4'b1011,
                           C_NOR = 4'b1100, C_XOR = 4'b1101, C_SLL = 4'b1110, C_SRL = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] in1 = '0, in2 = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic [31:0] result, result_hi;
    logic        zero_flag, carry_flag, ovf_flag, dz_flag;

    logic        in_valid_16 = 1'b0;
    logic        in_ready_16;
    logic [3:0]  op_16 = '0;
    logic [15:0] in1_16 = '0, in2_16 = '0;
    logic [3:0]  shamt_16 = '0;
    logic        out_valid_16;
    logic [15:0] result_16, result_hi_16;
    logic        zero_16, carry_16, ovf_16, dz_16;

    ula_mc #(.WIDTH(32), .SHW(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .in1(in1), .in2(in2), .shamt(shamt), .out_valid(out_valid), .result(result),
        .result_hi(result_hi), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .ovf_flag(ovf_flag), .dz_flag(dz_flag)
    );

    ula_mc #(.WIDTH(16), .SHW(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16), .op(op_16),
        .in1(in1_16), .in2(in2_16), .shamt(shamt_16), .out_valid(out_valid_16), .result(result_16),
        .result_hi(result_hi_16), .zero_flag(zero_16), .carry_flag(carry_16),
        .ovf_flag(ovf_16), .dz_flag(dz_16)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z, c, o, d;
    } out_t;

    out_t q_exp[$];
    int   q_lat[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference behaviour of one request: outputs and latency.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s, output out_t e, output int lat);
        logic [32:0] t;
        logic [63:0] p;
        e = '0;
        lat = 1;
        case (o)
            C_AND: e.res = a & b;
            C_OR:  e.res = a | b;
            C_SUB: begin
                e.res = a - b;
                e.c   = (a < b);
                e.o   = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            C_SLT: e.res = (a < b) ? 32'd1 : 32'd0;
            C_LUI: e.res = {b[15:0], 16'h0000};
            C_NOR: e.res = ~(a | b);
            C_XOR: e.res = a ^ b;
            C_SLL: e.res = b << s;
            C_SRL: e.res = b >> s;
            C_MUL: begin
                p     = 64'(a) * 64'(b);
                e.res = p[31:0];
                e.hi  = p[63:32];
                e.o   = (p[63:32] != 0);
                lat   = 33;
            end
`ifdef ULA_MC_DIV_EN
            C_DIV: begin
                if (b == 0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.d   = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                    lat   = 33;
                end
            end
`endif
            default: begin
                t     = 33'(a) + 33'(b);
                e.res = t[31:0];
                e.c   = t[32];
                e.o   = (a[31] == b[31]) && (t[31] != a[31]);
            end
        endcase
        e.z = (e.res == 0);
    endfunction

    function automatic out_t sample();
        return {result, result_hi, zero_flag, carry_flag, ovf_flag, dz_flag};
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        out_t e;
        int   l;
        model(o, a, b, s, e, l);
        q_exp.push_back(e);
        q_lat.push_back(l);
        in_valid = 1'b1; op = o; in1 = a; in2 = b; shamt = s;
    endtask

    // Waits (bounded) for out_valid; reports latency and cycles with in_ready low.
    task automatic collect(output out_t obs, output int lat, output int busy, output bit to);
        to = 1'b1; lat = 0; busy = 0; obs = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (out_valid) begin
                obs = sample();
                to = 1'b0;
                break;
            end
            if (!in_ready) busy++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_valid, result, result_hi, zero_flag, carry_flag, ovf_flag, dz_flag} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h %h %h flags %b%b%b%b ov %b, want all 0",
                     result, result_hi, zero_flag, carry_flag, ovf_flag, dz_flag, out_valid, 1'b0);
        end
        n_total++;
        if ({out_valid_16, result_16, result_hi_16, zero_16, carry_16, ovf_16, dz_16} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs16: got ov %b res %h hi %h, want 0", out_valid_16, result_16, result_hi_16);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1 || in_ready_16 !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got ready %b/%b ov %b, want 1/1 0", in_ready, in_ready_16, out_valid);
        end
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops [0:5];
        logic [31:0] av  [0:5];
        logic [31:0] bv  [0:5];
        out_t obs, e;
        int lat, busy, el;
        bit to;
        ops = '{C_ADD, C_SUB, C_SUB, C_ADD, C_SUB, C_ADD};
        av  = '{32'h7FFF_FFFF, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        bv  = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], av[i], bv[i], 5'd0);
            collect(obs, lat, busy, to);
            e = q_exp.pop_front();
            el = q_lat.pop_front();
            n_total++;
            if (to || obs !== e) begin
                n_bad++;
                $display("FAIL add_sub[%0d]: got %h want %h timeout %b", i, obs, e, to);
            end
            n_total++;
            if (lat !== el) begin
                n_bad++;
                $display("FAIL add_sub_lat[%0d]: got %0d want %0d", i, lat, el);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0] ops [0:13];
        out_t obs, e;
        int lat, busy, el;
        bit to;
        ops = '{C_AND, C_OR, C_SLT, C_SLT, C_LUI, C_NOR, C_XOR, C_SLL, C_SRL,
                4'b0011, 4'b0100, 4'b0101, 4'b1010, C_LUI};
        for (int i = 0; i < 14; i++) begin
            issue(ops[i], $urandom(), $urandom(), 5'($urandom_range(0, 31)));
            if (i == 2) begin in1 = 32'd7; in2 = 32'hF000_0000; q_exp.pop_back(); q_lat.pop_back();
                issue(ops[i], 32'd7, 32'hF000_0000, 5'd0); end
            collect(obs, lat, busy, to);
            e = q_exp.pop_front();
            el = q_lat.pop_front();
            n_total++;
            if (to || obs !== e || lat !== el) begin
                n_bad++;
                $display("FAIL logic_op%b: got %h lat %0d want %h lat %0d", ops[i], obs, lat, e, el);
            end
        end
    endtask

    task automatic test_hold();
        out_t obs, e;
        int lat, busy, el;
        bit to;
        issue(C_XOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 5'd0);
        collect(obs, lat, busy, to);
        e = q_exp.pop_front();
        el = q_lat.pop_front();
        n_total++;
        if (to || obs !== e || lat !== el) begin
            n_bad++;
            $display("FAIL hold_op: got %h want %h", obs, e);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0 || sample() !== e) begin
                n_bad++;
                $display("FAIL hold[%0d]: ov %b got %h want %h", i, out_valid, sample(), e);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] av [0:3];
        logic [31:0] bv [0:3];
        out_t obs, e;
        int lat, busy, el;
        bit to;
        av = '{32'hFFFF_FFFF, 32'd12345, $urandom(), $urandom()};
        bv = '{32'd2, 32'd678, $urandom(), 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(C_MUL, av[i], bv[i], 5'd0);
            collect(obs, lat, busy, to);
            e = q_exp.pop_front();
            el = q_lat.pop_front();
            n_total++;
            if (to || obs !== e) begin
                n_bad++;
                $display("FAIL mul[%0d]: got %h want %h timeout %b", i, obs, e, to);
            end
            n_total++;
            if (lat !== el || busy !== el - 1) begin
                n_bad++;
                $display("FAIL mul_timing[%0d]: lat %0d busy %0d want lat %0d busy %0d", i, lat, busy, el, el - 1);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] av [0:3];
        logic [31:0] bv [0:3];
        out_t obs, e;
        int lat, busy, el;
        bit to;
        av = '{32'd100, 32'd9, $urandom(), 32'd5};
        bv = '{32'd7, 32'd0, 32'($urandom_range(1, 65535)), 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(C_DIV, av[i], bv[i], 5'd0);
            collect(obs, lat, busy, to);
            e = q_exp.pop_front();
            el = q_lat.pop_front();
            n_total++;
            if (to || obs !== e) begin
                n_bad++;
                $display("FAIL div[%0d]: got %h want %h timeout %b", i, obs, e, to);
            end
            n_total++;
            if (lat !== el || busy !== el - 1) begin
                n_bad++;
                $display("FAIL div_timing[%0d]: lat %0d busy %0d want lat %0d", i, lat, busy, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [0:7];
        out_t e;
        int el;
        ops = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_SLL, C_SRL, C_NOR};
        issue(ops[0], $urandom(), $urandom(), 5'($urandom_range(0, 31)));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = q_exp.pop_front();
            el = q_lat.pop_front();
            n_total++;
            if (out_valid !== 1'b1 || sample() !== e || el !== 1) begin
                n_bad++;
                $display("FAIL b2b[%0d]: ov %b got %h want %h", i, out_valid, sample(), e);
            end
            if (i < 7) issue(ops[i+1], $urandom(), $urandom(), 5'($urandom_range(0, 31)));
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        out_t obs, e;
        int lat, busy, el, seen;
        bit to;
        in_valid = 1'b1; op = C_MUL; in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, result, result_hi, zero_flag, carry_flag, ovf_flag, dz_flag} !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear: got ov %b res %h hi %h, want 0", out_valid, result, result_hi);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_abort: got %0d out_valid ready %b, want 0 and 1", seen, in_ready);
        end
        issue(C_ADD, 32'd1, 32'd1, 5'd0);
        collect(obs, lat, busy, to);
        e = q_exp.pop_front();
        el = q_lat.pop_front();
        n_total++;
        if (to || obs !== e || lat !== el || obs.res !== 32'd2) begin
            n_bad++;
            $display("FAIL midreset_add: got %h lat %0d want %h lat %0d", obs, lat, e, el);
        end
    endtask

    task automatic test_width16();
        int seen, at;
        in_valid_16 = 1'b1; op_16 = C_SLL; in1_16 = 16'd0; in2_16 = 16'd1; shamt_16 = 4'd15;
        @(negedge clk);
        in_valid_16 = 1'b0;
        n_total++;
        if (out_valid_16 !== 1'b1 || result_16 !== 16'h8000 || result_hi_16 !== 16'h0 || zero_16 !== 1'b0) begin
            n_bad++;
            $display("FAIL w16_sll: ov %b got %h hi %h want 8000", out_valid_16, result_16, result_hi_16);
        end
        // 300*500 = 0x249F0; an ADD offered mid-multiply must be dropped.
        in_valid_16 = 1'b1; op_16 = C_MUL; in1_16 = 16'd300; in2_16 = 16'd500;
        seen = 0; at = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid_16 = 1'b0;
            if (i == 4) begin in_valid_16 = 1'b1; op_16 = C_ADD; in1_16 = 16'd1; in2_16 = 16'd1; end
            if (out_valid_16) begin
                seen++;
                if (seen == 1) begin
                    at = i + 1;
                    n_total++;
                    if (result_16 !== 16'h49F0 || result_hi_16 !== 16'h0002 || ovf_16 !== 1'b1) begin
                        n_bad++;
                        $display("FAIL w16_mul: got %h:%h ovf %b want 0002:49f0 ovf 1", result_hi_16, result_16, ovf_16);
                    end
                end
            end
        end
        n_total++;
        if (seen !== 1 || at !== 17) begin
            n_bad++;
            $display("FAIL w16_busy_ignore: got %0d pulses first at %0d, want 1 at 17", seen, at);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_hold();
        test_mul();
        test_div();
        test_back_to_back();
        test_width16();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
